imem_responder: RTL and testbench

- Instruction-memory responder serving the processor's fetch stage; the memory end of the PC → instruction interface.
- Accepts one fetch request (PC) at a time and returns a 32-bit instruction after a programmable number of wait states, with a valid/ready handshake on both sides.
- Provides a word-write program-load port so benches and boot logic can fill the memory.
- Sits between the processor's PC register and the IF/ID pipeline register.

---
 rtl/imem_responder.sv | 186 ++++++++++++++++++
 tb/tb_imem_responder.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/imem_responder.sv
// imem_responder: instruction-memory responder for the fetch stage.
// Accepts one PC request at a time, returns the addressed 32-bit word after
// WAIT_STATES cycles, and flags misaligned / out-of-range PCs with NOP_WORD.
// A word-write program-load port fills the memory in any state.
// Optional feature macro: IMEM_RESP_PC_EN adds resp_pc (PC paired with resp).
module imem_responder #(
  parameter int          DEPTH       = 16,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] NOP_WORD    = 32'h00000013
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic [31:0]              req_pc,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [31:0]              resp_instr,
  output logic                     resp_fault,
`ifdef IMEM_RESP_PC_EN
  output logic [31:0]              resp_pc,
`endif
  input  logic                     flush,
  input  logic                     prog_we,
  input  logic [$clog2(DEPTH)-1:0] prog_addr,
  input  logic [31:0]              prog_data
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  // Counter preload: the WAIT state is left when the counter reads zero,
  // so WAIT_STATES cycles of latency need a preload of WAIT_STATES-1.
  localparam logic [3:0] WAIT_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  // A PC faults when it is not word aligned or lies beyond the memory,
  // so high addresses never alias onto low words.
  function automatic logic addr_fault(input logic [31:0] pc);
    logic misaligned;
    logic out_of_range;
    misaligned   = (pc[1:0] != 2'b00);
    out_of_range = (pc[31:AW+2] != {(30-AW){1'b0}});
    addr_fault   = misaligned || out_of_range;
  endfunction

  logic [31:0] mem_q [DEPTH];

  logic [1:0]  state_q,  state_d;
  logic [3:0]  cnt_q,    cnt_d;
  logic        valid_q,  valid_d;
  logic [31:0] instr_q,  instr_d;
  logic        fault_q,  fault_d;
`ifdef IMEM_RESP_PC_EN
  logic [31:0] pc_q,     pc_d;
`endif

  logic          accept_s;
  logic [AW-1:0] rd_idx_s;
  logic [31:0]   rd_word_s;
  logic          rd_fault_s;

  // Program-load port; memory is deliberately untouched by reset and the
  // write happens even while a flush is in progress.
  always_ff @(posedge clock) begin
    if (prog_we) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Request-side handshake and read-port decode.
  always_comb begin
    req_ready  = (state_q == ST_IDLE) || ((state_q == ST_RESP) && resp_ready);
    accept_s   = req_valid && req_ready && !flush;
    rd_idx_s   = req_pc[AW+1:2];
    rd_word_s  = mem_q[rd_idx_s];
    rd_fault_s = addr_fault(req_pc);
  end

  // Next-state logic: flush beats everything, then a new acceptance, then
  // the per-state progression (wait countdown, response handshake).
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    instr_d = instr_q;
    fault_d = fault_q;
`ifdef IMEM_RESP_PC_EN
    pc_d    = pc_q;
`endif
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = 4'd0;
      valid_d = 1'b0;
    end else if (accept_s) begin
      // The read uses the pre-edge memory, so a same-edge prog write to the
      // same index is not visible in the captured word.
      if (rd_fault_s) begin
        instr_d = NOP_WORD;
        fault_d = 1'b1;
      end else begin
        instr_d = rd_word_s;
        fault_d = 1'b0;
      end
`ifdef IMEM_RESP_PC_EN
      pc_d    = req_pc;
`endif
      if (WAIT_STATES == 0) begin
        state_d = ST_RESP;
        cnt_d   = 4'd0;
        valid_d = 1'b1;
      end else begin
        state_d = ST_WAIT;
        cnt_d   = WAIT_LOAD;
        valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_IDLE;
          valid_d = 1'b0;
        end
        ST_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_d = ST_RESP;
            valid_d = 1'b1;
          end else begin
            cnt_d   = cnt_q - 4'd1;
            valid_d = 1'b0;
          end
        end
        ST_RESP: begin
          if (resp_ready) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            state_d = ST_RESP;
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = 4'd0;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  // State and response holding registers with asynchronous active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= 4'd0;
      valid_q <= 1'b0;
      instr_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      fault_q <= fault_d;
    end
  end

`ifdef IMEM_RESP_PC_EN
  // Captured request PC travelling with the response.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pc_q <= 32'd0;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign resp_pc = pc_q;
`endif

  assign resp_valid = valid_q;
  assign resp_instr = instr_q;
  assign resp_fault = fault_q;

endmodule

// File: tb/tb_imem_responder.sv
// Directed bench for imem_responder: three instances with WAIT_STATES of
// 1, 0 and 3 share clock, reset and the program-load port.
module tb_imem_responder;

  logic        clock;
  logic        reset;
  logic        prog_we;
  logic [3:0]  prog_addr;
  logic [31:0] prog_data;

  logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_ready, a_resp_fault, a_flush;
  logic [31:0] a_req_pc, a_resp_instr;
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_fault, b_flush;
  logic [31:0] b_req_pc, b_resp_instr;
  logic        c_req_valid, c_req_ready, c_resp_valid, c_resp_ready, c_resp_fault, c_flush;
  logic [31:0] c_req_pc, c_resp_instr;
`ifdef IMEM_RESP_PC_EN
  logic [31:0] a_resp_pc, b_resp_pc, c_resp_pc;
`endif

  logic [31:0] mem_m [16];
  logic [31:0] old_word;
  int          pass_cnt;
  int          total_cnt;

  imem_responder #(.DEPTH(16), .WAIT_STATES(1)) u_a (
    .clock(clock), .reset(reset),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_pc(a_req_pc),
    .resp_valid(a_resp_valid), .resp_ready(a_resp_ready),
    .resp_instr(a_resp_instr), .resp_fault(a_resp_fault),
`ifdef IMEM_RESP_PC_EN
    .resp_pc(a_resp_pc),
`endif
    .flush(a_flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  imem_responder #(.DEPTH(16), .WAIT_STATES(0)) u_b (
    .clock(clock), .reset(reset),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_pc(b_req_pc),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_instr(b_resp_instr), .resp_fault(b_resp_fault),
`ifdef IMEM_RESP_PC_EN
    .resp_pc(b_resp_pc),
`endif
    .flush(b_flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  imem_responder #(.DEPTH(16), .WAIT_STATES(3)) u_c (
    .clock(clock), .reset(reset),
    .req_valid(c_req_valid), .req_ready(c_req_ready), .req_pc(c_req_pc),
    .resp_valid(c_resp_valid), .resp_ready(c_resp_ready),
    .resp_instr(c_resp_instr), .resp_fault(c_resp_fault),
`ifdef IMEM_RESP_PC_EN
    .resp_pc(c_resp_pc),
`endif
    .flush(c_flush), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total_cnt++;
    assert (obs === expv) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
  endtask

  initial begin
    pass_cnt = 0; total_cnt = 0;
    reset = 1'b0; prog_we = 1'b0; prog_addr = 4'd0; prog_data = 32'd0;
    a_req_valid = 1'b0; a_req_pc = 32'd0; a_resp_ready = 1'b0; a_flush = 1'b0;
    b_req_valid = 1'b0; b_req_pc = 32'd0; b_resp_ready = 1'b0; b_flush = 1'b0;
    c_req_valid = 1'b0; c_req_pc = 32'd0; c_resp_ready = 1'b0; c_flush = 1'b0;
    tick(); tick();

    // Reset state
    check("rst_valid", 32'(a_resp_valid), 32'd0);
    check("rst_instr", a_resp_instr, 32'd0);
    check("rst_fault", 32'(a_resp_fault), 32'd0);
    check("rst_ready", 32'(a_req_ready), 32'd1);
    reset = 1'b1;

    // Program load
    for (int i = 0; i < 16; i++) begin
      if (i == 0)      mem_m[i] = 32'h002081B3;
      else if (i == 1) mem_m[i] = 32'h40208233;
      else             mem_m[i] = 32'hA0000000 | 32'(i);
      prog_we = 1'b1; prog_addr = 4'(i); prog_data = mem_m[i];
      tick();
    end
    prog_we = 1'b0;

    // WAIT_STATES=1 basic fetches, second request accepted on the handshake edge
    a_resp_ready = 1'b1; a_req_valid = 1'b1; a_req_pc = 32'd0;
    tick();
    a_req_valid = 1'b0;
    check("ws1_lat_lo", 32'(a_resp_valid), 32'd0);
    tick();
    check("ws1_valid0", 32'(a_resp_valid), 32'd1);
    check("ws1_instr0", a_resp_instr, 32'h002081B3);
    check("ws1_fault0", 32'(a_resp_fault), 32'd0);
    a_req_valid = 1'b1; a_req_pc = 32'd4;
    tick();
    a_req_valid = 1'b0;
    check("ws1_b2b_lo", 32'(a_resp_valid), 32'd0);
    tick();
    check("ws1_valid1", 32'(a_resp_valid), 32'd1);
    check("ws1_instr1", a_resp_instr, 32'h40208233);
`ifdef IMEM_RESP_PC_EN
    check("ws1_pc1", a_resp_pc, 32'd4);
`endif
    tick();
    check("ws1_idle", 32'(a_resp_valid), 32'd0);

    // WAIT_STATES=0 streaming, one response per cycle
    b_resp_ready = 1'b1; b_req_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      b_req_pc = 32'(4 * k);
      tick();
      check($sformatf("stream_valid%0d", k), 32'(b_resp_valid), 32'd1);
      check($sformatf("stream_instr%0d", k), b_resp_instr, mem_m[k]);
    end
    b_req_valid = 1'b0;
    tick();
    check("stream_end", 32'(b_resp_valid), 32'd0);

    // Fault cases and last valid word
    a_req_valid = 1'b1; a_req_pc = 32'h00000042;
    tick(); a_req_valid = 1'b0; tick();
    check("mis_instr", a_resp_instr, 32'h00000013);
    check("mis_fault", 32'(a_resp_fault), 32'd1);
    a_req_valid = 1'b1; a_req_pc = 32'h00000040;
    tick(); a_req_valid = 1'b0; tick();
    check("oor_instr", a_resp_instr, 32'h00000013);
    check("oor_fault", 32'(a_resp_fault), 32'd1);
    a_req_valid = 1'b1; a_req_pc = 32'h0000003C;
    tick(); a_req_valid = 1'b0; tick();
    check("last_instr", a_resp_instr, mem_m[15]);
    check("last_fault", 32'(a_resp_fault), 32'd0);
    tick();

    // Same-edge write and accept: old word captured, new word seen next time
    a_req_valid = 1'b1; a_req_pc = 32'd8;
    prog_we = 1'b1; prog_addr = 4'd2; prog_data = 32'hDEADBEEF;
    tick();
    prog_we = 1'b0; a_req_valid = 1'b0;
    old_word = mem_m[2]; mem_m[2] = 32'hDEADBEEF;
    tick();
    check("wr_acc_old", a_resp_instr, old_word);
    tick();
    a_req_valid = 1'b1; a_req_pc = 32'd8;
    tick(); a_req_valid = 1'b0; tick();
    check("wr_acc_new", a_resp_instr, 32'hDEADBEEF);
    tick();

    // Backpressure: hold resp_ready low for 5 cycles in RESP
    a_resp_ready = 1'b0; a_req_valid = 1'b1; a_req_pc = 32'h0000000C;
    tick(); a_req_valid = 1'b0; tick();
    check("hold_valid", 32'(a_resp_valid), 32'd1);
    a_req_valid = 1'b1; a_req_pc = 32'h00000010;
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("hold_valid%0d", k), 32'(a_resp_valid), 32'd1);
      check($sformatf("hold_instr%0d", k), a_resp_instr, mem_m[3]);
      check($sformatf("hold_rdy%0d", k), 32'(a_req_ready), 32'd0);
    end
    a_req_valid = 1'b0; a_resp_ready = 1'b1;
    #1;
    check("hold_rdy_on", 32'(a_req_ready), 32'd1);
    tick();
    check("hold_done", 32'(a_resp_valid), 32'd0);
    tick();
    check("hold_once", 32'(a_resp_valid), 32'd0);

    // Flush during WAIT (WAIT_STATES=3) with a simultaneous prog write
    c_resp_ready = 1'b1; c_req_valid = 1'b1; c_req_pc = 32'd8;
    tick();
    c_req_valid = 1'b0; c_flush = 1'b1;
    prog_we = 1'b1; prog_addr = 4'd5; prog_data = 32'hCAFE0005;
    tick();
    c_flush = 1'b0; prog_we = 1'b0; mem_m[5] = 32'hCAFE0005;
    for (int k = 0; k < 6; k++) begin
      check($sformatf("flush_quiet%0d", k), 32'(c_resp_valid), 32'd0);
      tick();
    end
    c_req_valid = 1'b1; c_req_pc = 32'd12;
    tick(); c_req_valid = 1'b0;
    check("ws3_e0", 32'(c_resp_valid), 32'd0);
    tick();
    check("ws3_e1", 32'(c_resp_valid), 32'd0);
    tick();
    check("ws3_e2", 32'(c_resp_valid), 32'd0);
    tick();
    check("ws3_e3", 32'(c_resp_valid), 32'd1);
    check("ws3_instr", c_resp_instr, mem_m[3]);
    tick();
    c_req_valid = 1'b1; c_req_pc = 32'd20;
    tick(); c_req_valid = 1'b0; tick(); tick(); tick();
    check("flush_wr_valid", 32'(c_resp_valid), 32'd1);
    check("flush_wr_instr", c_resp_instr, 32'hCAFE0005);
    tick();

    // Flush in IDLE with req_valid high: request ignored
    c_req_valid = 1'b1; c_req_pc = 32'd0; c_flush = 1'b1;
    tick();
    c_req_valid = 1'b0; c_flush = 1'b0;
    for (int k = 0; k < 5; k++) begin
      check($sformatf("flush_idle%0d", k), 32'(c_resp_valid), 32'd0);
      tick();
    end

    // Asynchronous reset while in WAIT; memory survives
    c_req_valid = 1'b1; c_req_pc = 32'd0;
    tick(); c_req_valid = 1'b0; tick();
    check("pre_rst_rdy", 32'(c_req_ready), 32'd0);
    reset = 1'b0;
    #1;
    check("async_valid", 32'(c_resp_valid), 32'd0);
    check("async_rdy", 32'(c_req_ready), 32'd1);
    tick();
    reset = 1'b1;
    c_req_valid = 1'b1; c_req_pc = 32'd4;
    tick(); c_req_valid = 1'b0; tick(); tick(); tick();
    check("post_rst_valid", 32'(c_resp_valid), 32'd1);
    check("post_rst_instr", c_resp_instr, mem_m[1]);
    tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
